instr_encoder: RTL
==================

Name: instr_encoder

Overview:
- Inverse of the decode-side immediate extraction: packs opcode, register fields, funct fields and a 32-bit signed immediate into a standard RV32I instruction word.
- Used by the boot/test-program loader to build instruction-memory images on chip.
- Single registered output stage with valid/ready backpressure.
- Tracks the instruction-memory write address, range-checks immediates, and counts encode errors.

Parameters:
- BASE_ADDR, 32'h0000_0000, address assigned to the first emitted instruction and restored by reset.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  encoder can accept a request.
- fmt  in  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6/7 illegal.
- opcode  in  7  placed in bits [6:0].
- rd, rs1, rs2  in  5 each  register fields.
- funct3  in  3  bits [14:12] (R/I/S/B).
- funct7  in  7  bits [31:25] (R only).
- imm  in  32  signed immediate; byte offset for B and J; full value for U.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  consumer accepts the word.
- instr  out  32  encoded instruction.
- addr  out  32  memory address of instr.
- err  out  1  the immediate or fmt of instr was illegal.
- err_count  out  ERR_CNT_W  saturating count of emitted words with err=1.

Behaviour:
- Reset values: out_valid=0, instr=0, addr=BASE_ADDR, err=0, err_count=0. in_ready=1 in the cycle after reset.
- Reset has priority over everything, including a word held mid-handshake, which is discarded.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept when in_valid && in_ready. The result is registered, giving 1-cycle latency.
  - Output transfers when out_valid && out_ready.
  - While out_valid && !out_ready, instr/addr/err are held stable.
  - Simultaneous output transfer and input accept in the same cycle: out_valid stays 1 and the new word loads (full throughput, 1 word/cycle).
- addr:
  - Holds the address of the word currently in the output register.
  - After each output transfer, the next word's address is the previous addr + 4, wrapping modulo 2^32.
  - The first word after reset gets BASE_ADDR.
  - Implement with a next-address register; addr is updated on load.
- Encoding (bit ranges MSB..LSB):
  - R: funct7, rs2, rs1, funct3, rd, opcode.
  - I: imm[11:0], rs1, funct3, rd, opcode.
  - S: imm[11:5], rs2, rs1, funct3, imm[4:0], opcode.
  - B: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode.
  - U: imm[31:12], rd, opcode.
  - J: imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode.
  - Fields unused by a format are ignored.
- Error checks (err registered with the word):
  - I, S: err if imm is outside [-2048, 2047].
  - B: err if imm is outside [-4096, 4094], or imm[0]=1.
  - J: err if imm is outside [-1048576, 1048574], or imm[0]=1.
  - U: err if imm[11:0] != 0.
  - R: never errs.
  - fmt 6/7: err=1 and instr=32'h0000_0013 (NOP).
- On a range error, the word is still encoded from the truncated bits listed above and emitted.
- err_count increments on each output transfer with err=1 and saturates at all-ones.

Test Plan:
- Reset, then I-format addi x1,x0,5 (opcode 0010011, rd=1, funct3=0, imm=5), out_ready=1 -> next cycle out_valid=1, instr=32'h00500093, addr=32'h0, err=0.
- S-format sw x2,8(x1) (opcode 0100011, rs1=1, rs2=2, funct3=010, imm=8) after the first word -> instr=32'h0020A423, addr=32'h4.
- B-format beq x0,x0,-4 (opcode 1100011) -> instr=32'hFE000EE3. Then J-format jal x1,2048 (opcode 1101111, rd=1) -> instr=32'h001000EF. Then U-format lui x5,32'h12345000 (opcode 0110111) -> instr=32'h123452B7. Each word sets err=0.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, instr/addr held. Then out_ready=1 with back-to-back requests -> one word per cycle, addr steps +4 per transfer.
- Errors: I-format imm=2048, B-format imm=3, U-format imm=32'h1, fmt=7 -> each emitted word has err=1, the fmt=7 word is instr=32'h00000013, and err_count=4. With ERR_CNT_W=2, 5 errors -> err_count=3.
- Reset asserted while out_valid=1, out_ready=0 -> next cycle out_valid=0, addr=BASE_ADDR, err_count=0. The next word encodes at BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder_if.sv
// Request/response bundle of the RV32I instruction encoder.
// Request: in_valid/in_ready plus instruction fields.
// Response: out_valid/out_ready, instr, addr, err, err_count.
// master = program loader side, slave = encoder side.
interface instr_encoder_if #(
    parameter int ERR_CNT_W = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           fmt;
    logic [6:0]           opcode;
    logic [4:0]           rd;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [2:0]           funct3;
    logic [6:0]           funct7;
    logic [31:0]          imm;
    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          instr;
    logic [31:0]          addr;
    logic                 err;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output in_valid, fmt, opcode, rd, rs1, rs2,
               funct3, funct7, imm, out_ready,
        input  in_ready, out_valid, instr, addr,
               err, err_count
    );

    modport slave (
        input  in_valid, fmt, opcode, rd, rs1, rs2,
               funct3, funct7, imm, out_ready,
        output in_ready, out_valid, instr, addr,
               err, err_count
    );
endinterface

// File: rtl/instr_encoder.sv
// RV32I instruction encoder with one registered output stage.
// Ports: clk, reset (sync, active-high), bus (instr_encoder_if.slave):
//   request fields in, encoded instr/addr/err out, saturating err_count.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ERR_CNT_W = 8
) (
    input logic           clk,
    input logic           reset,
    instr_encoder_if.slave bus
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0] next_addr;
    logic [31:0] enc;
    logic        enc_err;
    logic        accept;
    logic        xfer;
    logic        fit12;
    logic        fit13;
    logic        fit21;

    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign xfer         = bus.out_valid && bus.out_ready;

    // Signed range checks: value fits N bits when all bits above
    // the sign bit equal the sign bit.
    assign fit12 = (&bus.imm[31:11]) || !(|bus.imm[31:11]);
    assign fit13 = (&bus.imm[31:12]) || !(|bus.imm[31:12]);
    assign fit21 = (&bus.imm[31:20]) || !(|bus.imm[31:20]);

    always_comb begin
        enc     = NOP;
        enc_err = 1'b0;
        unique case (bus.fmt)
            3'd0: begin
                enc = {bus.funct7, bus.rs2, bus.rs1,
                       bus.funct3, bus.rd, bus.opcode};
            end
            3'd1: begin
                enc = {bus.imm[11:0], bus.rs1,
                       bus.funct3, bus.rd, bus.opcode};
                enc_err = !fit12;
            end
            3'd2: begin
                enc = {bus.imm[11:5], bus.rs2, bus.rs1,
                       bus.funct3, bus.imm[4:0], bus.opcode};
                enc_err = !fit12;
            end
            3'd3: begin
                enc = {bus.imm[12], bus.imm[10:5], bus.rs2,
                       bus.rs1, bus.funct3, bus.imm[4:1],
                       bus.imm[11], bus.opcode};
                enc_err = !fit13 || bus.imm[0];
            end
            3'd4: begin
                enc = {bus.imm[31:12], bus.rd, bus.opcode};
                enc_err = |bus.imm[11:0];
            end
            3'd5: begin
                enc = {bus.imm[20], bus.imm[10:1], bus.imm[11],
                       bus.imm[19:12], bus.rd, bus.opcode};
                enc_err = !fit21 || bus.imm[0];
            end
            default: begin
                enc     = NOP;
                enc_err = 1'b1;
            end
        endcase
    end

    // Every loaded word is guaranteed to transfer before the next
    // load (or be wiped by reset), so advancing the address on load
    // gives each transferred word the previous address + 4.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.instr     <= '0;
            bus.addr      <= BASE_ADDR;
            bus.err       <= 1'b0;
            bus.err_count <= '0;
            next_addr     <= BASE_ADDR;
        end else begin
            if (xfer && bus.err && !(&bus.err_count)) begin
                bus.err_count <= bus.err_count + 1'b1;
            end
            if (accept) begin
                bus.out_valid <= 1'b1;
                bus.instr     <= enc;
                bus.err       <= enc_err;
                bus.addr      <= next_addr;
                next_addr     <= next_addr + 32'd4;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule
